sprite_compositor: RTL and testbench



---
 rtl/sprite_compositor.sv | 137 +++++++++++++
 tb/tb_sprite_compositor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Sprite compositor: overlays NUM_SPRITES one-bit sprites on a one-bit background, registered RGB444 out.
// Collision detection is built only when the SPRITE_COLLISION_EN macro is defined.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W = 60,
    parameter int SPR_H = 60,
    parameter int FRAMES = 3,
    parameter int ADDR_W = 14,
    parameter logic [NUM_SPRITES*12-1:0] SPR_COLORS = '0,
    parameter logic [11:0] BG_ON_COLOR = 12'h000,
    parameter logic [11:0] BG_OFF_COLOR = 12'hfff
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pix_en,
    input  logic [9:0]                    x,
    input  logic [8:0]                    y,
    input  logic                          active,
    input  logic                          frame_end,
    input  logic [NUM_SPRITES*10-1:0]     sprite_x,
    input  logic [NUM_SPRITES*9-1:0]      sprite_y,
    input  logic [NUM_SPRITES-1:0]        sprite_en,
    input  logic [NUM_SPRITES*2-1:0]      sprite_frame,
    output logic [NUM_SPRITES*ADDR_W-1:0] sprite_addr,
    input  logic [NUM_SPRITES-1:0]        sprite_data,
    input  logic                          bg_data,
    output logic [11:0]                   color,
    output logic [NUM_SPRITES-1:0]        collision_mask,
    output logic                          collision_valid
);

    localparam logic [10:0]       SPR_W_X     = 11'(SPR_W);
    localparam logic [10:0]       SPR_H_Y     = 11'(SPR_H);
    localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SPR_W * SPR_H);

    // Elaboration guard: all animation frames of one sprite must be addressable.
    if (SPR_W * SPR_H * FRAMES > (1 << ADDR_W)) begin : g_addr_check
        $error("sprite image does not fit in ADDR_W");
    end

    logic [NUM_SPRITES-1:0] hit;
    logic [NUM_SPRITES-1:0] hit_d;
    logic [NUM_SPRITES-1:0] vis;
    logic                   active_d;
    logic [ADDR_W-1:0]      offset [NUM_SPRITES];
    logic [11:0]            color_next;

    // Bounds compared at 11 bits so a sprite near the right/bottom edge never wraps to 0.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = sprite_en[i]
                && ({1'b0, x} >= {1'b0, sprite_x[i*10 +: 10]})
                && ({1'b0, x} <  ({1'b0, sprite_x[i*10 +: 10]} + SPR_W_X))
                && ({2'b00, y} >= {2'b00, sprite_y[i*9 +: 9]})
                && ({2'b00, y} <  ({2'b00, sprite_y[i*9 +: 9]} + SPR_H_Y));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) offset[i] <= '0;
        end else if (frame_end) begin
            for (int i = 0; i < NUM_SPRITES; i++) offset[i] <= '0;
        end else if (pix_en) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (hit[i]) offset[i] <= offset[i] + 1'b1;
            end
        end
    end

    always_comb begin
        sprite_addr = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            sprite_addr[i*ADDR_W +: ADDR_W] =
                ADDR_W'(sprite_frame[i*2 +: 2]) * FRAME_WORDS + offset[i];
        end
    end

    // RAM data arrives one pixel late; delay hit/active by the same amount.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_d    <= '0;
            active_d <= 1'b0;
        end else if (pix_en) begin
            hit_d    <= hit;
            active_d <= active;
        end
    end

    assign vis = hit_d & sprite_data;

    always_comb begin
        color_next = bg_data ? BG_ON_COLOR : BG_OFF_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (vis[i]) color_next = SPR_COLORS[i*12 +: 12];
        end
        if (!active_d) color_next = 12'h000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color <= 12'h000;
        end else if (pix_en) begin
            color <= color_next;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] coll_acc;
    logic [NUM_SPRITES-1:0] contrib;
    logic                   multi;

    // Clearing the lowest set bit leaves something only when two or more channels are set.
    assign multi   = |(vis & (vis - NUM_SPRITES'(1)));
    assign contrib = (pix_en && multi) ? vis : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_acc        <= '0;
            collision_mask  <= '0;
            collision_valid <= 1'b0;
        end else if (frame_end) begin
            collision_mask  <= coll_acc;
            collision_valid <= |coll_acc;
            coll_acc        <= contrib;
        end else begin
            collision_valid <= 1'b0;
            coll_acc        <= coll_acc | contrib;
        end
    end
`else
    assign collision_mask  = '0;
    assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: behavioural RAM models, a reference pixel model
// and a scoreboard queue of expected colours compared one pixel after each pixel is driven.
module tb_sprite_compositor;

    localparam int NS = 4;
    localparam int AW = 14;
    localparam logic [NS*12-1:0] COLS   = {12'hff0, 12'h00f, 12'h0f0, 12'hf00};
    localparam logic [11:0]      BG_ON  = 12'h123;
    localparam logic [11:0]      BG_OFF = 12'hfff;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_en;
    logic [9:0]        x;
    logic [8:0]        y;
    logic              active;
    logic              frame_end;
    logic [NS*10-1:0]  sprite_x;
    logic [NS*9-1:0]   sprite_y;
    logic [NS-1:0]     sprite_en;
    logic [NS*2-1:0]   sprite_frame;
    logic [NS*AW-1:0]  sprite_addr;
    logic [NS-1:0]     sprite_data;
    logic              bg_data;
    logic [11:0]       color;
    logic [NS-1:0]     collision_mask;
    logic              collision_valid;

    sprite_compositor #(
        .NUM_SPRITES(NS), .SPR_W(60), .SPR_H(60), .FRAMES(3), .ADDR_W(AW),
        .SPR_COLORS(COLS), .BG_ON_COLOR(BG_ON), .BG_OFF_COLOR(BG_OFF)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y),
        .active(active), .frame_end(frame_end),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .sprite_frame(sprite_frame), .sprite_addr(sprite_addr),
        .sprite_data(sprite_data), .bg_data(bg_data), .color(color),
        .collision_mask(collision_mask), .collision_valid(collision_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] c;
        int          px;
        int          py;
    } exp_t;

    exp_t        q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          pat_mode = 0;
    int          sx[NS], sy[NS], fr[NS];
    logic [NS-1:0] en;
    int          m_off[NS];
    logic [NS-1:0] m_acc;
    logic [NS*12-1:0] cols_v;

    function automatic logic pat(int a);
        if (pat_mode == 0) return 1'b1;
        return a[0] ^ a[5];
    endfunction

    function automatic logic bgf(int xx, int yy);
        return xx[2] ^ yy[1];
    endfunction

    // Sprite and background RAMs: one pix_en of read latency.
    always @(posedge clk) begin
        if (pix_en) begin
            for (int i = 0; i < NS; i++) sprite_data[i] <= pat(int'(sprite_addr[i*AW +: AW]));
            bg_data <= bgf(int'(x), int'(y));
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NS; i++) begin
            sprite_x[i*10 +: 10]  = 10'(sx[i]);
            sprite_y[i*9 +: 9]    = 9'(sy[i]);
            sprite_frame[i*2 +: 2] = 2'(fr[i]);
        end
        sprite_en = en;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NS; i++) m_off[i] = 0;
        m_acc = '0;
    endtask

    task automatic pix(int px, int py, bit act);
        logic [NS-1:0] vis;
        logic [11:0]   e;
        exp_t          ent;
        exp_t          old;
        int            a;
        x = 10'(px); y = 9'(py); active = act; pix_en = 1'b1; frame_end = 1'b0;
        #1;
        vis = '0;
        for (int i = 0; i < NS; i++) begin
            if (en[i] && px >= sx[i] && px < sx[i] + 60 && py >= sy[i] && py < sy[i] + 60) begin
                a = fr[i] * 3600 + m_off[i];
                check($sformatf("addr%0d(%0d,%0d)", i, px, py), 32'(sprite_addr[i*AW +: AW]), 32'(a));
                vis[i] = pat(a);
                m_off[i]++;
            end
        end
        e = bgf(px, py) ? BG_ON : BG_OFF;
        for (int i = NS - 1; i >= 0; i--) if (vis[i]) e = cols_v[i*12 +: 12];
        if (!act) e = 12'h000;
        if ((vis & (vis - 4'd1)) != '0) m_acc = m_acc | vis;
        ent.c = e; ent.px = px; ent.py = py;
        q.push_back(ent);
        @(posedge clk); #1;
        if (q.size() == 2) begin
            old = q.pop_front();
            check($sformatf("color(%0d,%0d)", old.px, old.py), 32'(color), 32'(old.c));
        end
    endtask

    task automatic fend();
        logic [NS-1:0] em;
        pix(1023, 511, 1'b0);
        pix_en = 1'b0; frame_end = 1'b1;
        em = m_acc;
        clear_model();
        @(posedge clk); #1;
        frame_end = 1'b0;
`ifdef SPRITE_COLLISION_EN
        check("coll_mask", 32'(collision_mask), 32'(em));
        check("coll_valid", 32'(collision_valid), 32'(em != '0));
`else
        check("coll_mask_off", 32'(collision_mask), 32'(0));
        check("coll_valid_off", 32'(collision_valid), 32'(0));
`endif
        @(posedge clk); #1;
        check("coll_valid_pulse", 32'(collision_valid), 32'(0));
        for (int i = 0; i < NS; i++)
            check($sformatf("addr%0d_after_fend", i), 32'(sprite_addr[i*AW +: AW]), 32'(fr[i] * 3600));
    endtask

    initial begin
        cols_v = COLS;
        reset = 1'b1; pix_en = 1'b0; x = '0; y = '0; active = 1'b0; frame_end = 1'b0;
        for (int i = 0; i < NS; i++) begin sx[i] = 0; sy[i] = 0; fr[i] = 0; end
        en = '0;
        apply_cfg();
        clear_model();
        #12;
        check("reset_color", 32'(color), 32'(0));
        check("reset_mask", 32'(collision_mask), 32'(0));
        check("reset_valid", 32'(collision_valid), 32'(0));
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++)
            check($sformatf("reset_addr%0d", i), 32'(sprite_addr[i*AW +: AW]), 32'(0));

        // Single sprite, edge pixels and blanking.
        sx[0] = 100; sy[0] = 50; en = 4'b0001; apply_cfg();
        pix(99, 50, 1); pix(100, 50, 1); pix(101, 50, 1); pix(102, 50, 0);
        pix(159, 50, 1); pix(160, 50, 1); pix(100, 49, 1); pix(100, 109, 1); pix(100, 110, 1);
        fend();

        // Full sprite scan on channel 1, animation frame 1, patterned data.
        en = 4'b0010; sx[1] = 90; sy[1] = 40; fr[1] = 1; pat_mode = 1; apply_cfg();
        for (int yy = 38; yy < 102; yy++)
            for (int xx = 88; xx < 152; xx++) pix(xx, yy, 1);
        check("offset_full", 32'(sprite_addr[1*AW +: AW]), 32'(7200));
        fend();

        // Overlap of channels 0 and 2: priority and collision.
        en = 4'b0101; sx[0] = 200; sy[0] = 200; sx[2] = 220; sy[2] = 210;
        fr[1] = 0; pat_mode = 0; apply_cfg();
        pix(200, 200, 1); pix(225, 215, 1); pix(270, 215, 1);
        fend();
        en = 4'b0001; apply_cfg();
        pix(225, 215, 1);
        fend();
        en = 4'b0101; pat_mode = 1; apply_cfg();
        for (int yy = 208; yy < 212; yy++)
            for (int xx = 216; xx < 228; xx++) pix(xx, yy, 1);
        fend();

        // Right-edge sprite must not wrap to x=0.
        en = 4'b1000; sx[3] = 600; sy[3] = 100; pat_mode = 0; apply_cfg();
        for (int yy = 100; yy < 102; yy++) begin
            for (int xx = 0; xx < 25; xx++) pix(xx, yy, 1);
            for (int xx = 595; xx < 640; xx++) pix(xx, yy, 1);
        end
        fend();

        // Mid-line reset with a collision mask pending, then frame 2 addressing.
        en = 4'b0101; sx[0] = 200; sy[0] = 200; sx[2] = 220; sy[2] = 210; apply_cfg();
        pix(225, 215, 1); pix(226, 215, 1);
        fend();
        pix(200, 200, 1); pix(201, 200, 1); pix(202, 200, 1);
        #2; reset = 1'b1; #1;
        check("midreset_color", 32'(color), 32'(0));
        check("midreset_mask", 32'(collision_mask), 32'(0));
        check("midreset_valid", 32'(collision_valid), 32'(0));
        check("midreset_addr0", 32'(sprite_addr[0 +: AW]), 32'(0));
        pix_en = 1'b0;
        q.delete();
        clear_model();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        en = 4'b0001; fr[0] = 2; apply_cfg();
        pix(205, 200, 1); pix(206, 200, 1);
        fend();
        pix(199, 200, 1); pix(200, 200, 1); pix(201, 200, 1); pix(200, 201, 1);
        fend();
        pix(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
